osd_hex_overlay_multi: RTL and testbench
========================================

Name: osd_hex_overlay_multi

Overview:
Parametrised debug OSD that renders NUM_VALUES hex words, each DIGITS nibbles wide, as a text block over the live video stream. It has a built-in 8x8 hex font, an optional scaled glyph size and a selectable background box mode. Each frame it snapshots the debug values so the text never tears mid-frame. It sits inline between the core video output and the scaler/Analogizer video path, and delays video and sync by a fixed pipeline latency.

Parameters:
NUM_VALUES, 4, number of debug words; one text line each, 1..8
DIGITS, 2, hex digits per word, 1..8; word width W = 4*DIGITS
X_ORIGIN, 16, first active pixel column of the text block
Y_ORIGIN, 16, first active line of the text block
SCALE, 1, glyph magnification, 1 or 2 (pixel and line doubling)
BG_MODE, 1, background inside the box: 0 transparent, 1 dim (input RGB >> 1), 2 black
FG_RGB, 24'hFFFFFF, glyph colour {R,G,B}

Ports:
clk  in  1  video clock
reset_n  in  1  synchronous reset, active low
pixel_ce  in  1  pixel clock enable; all state advances only when high
enable  in  1  overlay on; when low, video passes through with the same latency
values  in  NUM_VALUES*W  packed words; word i is values[i*W +: W]
RGB_in_R/G/B  in  8 each  input colour
HS, VS, HBLANK, VBLANK  in  1 each  input sync and blanking
RGB_out_R/G/B  out  8 each  output colour
HS_out, VS_out, HBLANK_out, VBLANK_out  out  1 each  sync and blanking delayed to match RGB

Behaviour:
- Reset (reset_n low at a clk edge, checked regardless of pixel_ce): all outputs 0, hpos/vpos 0, snapshot registers 0, pipeline registers 0. Reset asserted mid-frame takes effect immediately. After release, output is valid from the next frame; the partial frame shows all-zero digits.
- Position counters (advance on pixel_ce only): hpos = 10-bit active-pixel index. Cleared while HBLANK=1, incremented per active pixel, saturates at 1023. vpos = 10-bit active-line index. Cleared while VBLANK=1, incremented on the HBLANK rising edge when VBLANK=0, saturates at 1023.
- Snapshot: on the VBLANK rising edge (sampled on pixel_ce) all words are copied into an internal snapshot. Rendering uses only the snapshot. A change on values mid-frame is invisible until the next frame.
- Box geometry: GW = 8*SCALE. The box spans hpos X_ORIGIN .. X_ORIGIN + DIGITS*GW - 1 and vpos Y_ORIGIN .. Y_ORIGIN + NUM_VALUES*GW - 1.
- Cell decode inside the box: dx = hpos - X_ORIGIN, dy = vpos - Y_ORIGIN.
  - line = dy / GW; digit = dx / GW, where digit 0 is the most significant nibble.
  - glyph row = (dy % GW) / SCALE; glyph col = (dx % GW) / SCALE.
  - nibble = snapshot[line] bits [W-1-4*digit -: 4].
  - Font ROM: 16 glyphs, 0-9 and A-F, 8 rows of 8 bits. Bit 7 is the leftmost column. Column 7 and row 7 are blank for spacing.
- Pipeline: 2 pixel_ce stages.
  - S1 registers the in-box flag, nibble, glyph row/col, input RGB and syncs.
  - S2 reads the font bit and mixes.
  - Outputs change only on pixel_ce. Latency is exactly 2 pixel_ce ticks for every output, including HS/VS/blank and when enable=0.
- Mix in S2, highest priority first:
  1. delayed HBLANK|VBLANK: RGB 0.
  2. enable=0 or outside box: input RGB.
  3. glyph bit=1: FG_RGB.
  4. otherwise, by BG_MODE: input RGB, {1'b0, in[7:1]} per channel, or 0.
- enable is sampled in S1, so toggling it mid-line affects pixels from that tick on, with no glitch in sync outputs.
- Box clipping: if the box extends past the active area, the excess is simply never reached. There is no wrap-around; saturated counters never re-enter the box.

Test Plan:
- Reset: hold reset_n=0 for 5 pixel_ce ticks with active video -> all outputs 0. After release, HS_out/VS_out follow HS/VS delayed by exactly 2 pixel_ce.
- Basic render (NUM_VALUES=2, DIGITS=2, X_ORIGIN=16, Y_ORIGIN=8, SCALE=1, BG_MODE=2, values=16'h3CA5): frame 2 captured -> line 0 shows "A5", line 1 shows "3C". Pixel (16,8) matches font row 0, col 0 of 'A'. Pixel (31,23) is 0 (black box).
- Snapshot: change values to 16'h0000 mid-frame -> remainder of that frame still shows A5/3C; the next frame shows 00/00.
- Modes: BG_MODE=1 with input RGB=8'hC8 -> non-glyph box pixels = 8'h64 and outside-box pixels = 8'hC8. enable=0 -> whole frame equals input delayed by 2 ticks.
- SCALE=2: box spans 32x32 from (16,8); each font bit covers 2x2 output pixels. Pixel (47,39) lies at the box edge and shows background.
- pixel_ce duty 1/2 and 1/4: output stream is identical to the duty-1 run, compared per pixel_ce sample. No state change occurs on clk edges with pixel_ce=0.

Source files
------------

// File: rtl/osd_hex_overlay_multi.sv
// osd_hex_overlay_multi
//   Debug on-screen display: renders NUM_VALUES hex words (DIGITS nibbles
//   each) as a text block over live video using a built-in 8x8 hex font.
//   Debug words are snapshotted at the start of vertical blanking, so the
//   text never tears mid-frame. Video and sync are delayed by exactly two
//   pixel_ce ticks, whether or not the overlay is enabled.
//
// Ports
//   clk          video clock
//   reset_n      synchronous reset, active low (honoured regardless of pixel_ce)
//   pixel_ce     pixel clock enable; all state advances only when high
//   enable       overlay on; when low, video passes through with the same latency
//   values       packed debug words, word i = values[i*W +: W]
//   RGB_in_R/G/B input colour
//   HS/VS/HBLANK/VBLANK  input sync and blanking
//   RGB_out_R/G/B        output colour
//   HS_out/VS_out/HBLANK_out/VBLANK_out  sync and blanking delayed to match RGB
module osd_hex_overlay_multi #(
   parameter int          NUM_VALUES = 4,
   parameter int          DIGITS     = 2,
   parameter int          X_ORIGIN   = 16,
   parameter int          Y_ORIGIN   = 16,
   parameter int          SCALE      = 1,
   parameter int          BG_MODE    = 1,
   parameter logic [23:0] FG_RGB     = 24'hFFFFFF
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           pixel_ce,
   input  logic                           enable,
   input  logic [NUM_VALUES*4*DIGITS-1:0] values,
   input  logic [7:0]                     RGB_in_R,
   input  logic [7:0]                     RGB_in_G,
   input  logic [7:0]                     RGB_in_B,
   input  logic                           HS,
   input  logic                           VS,
   input  logic                           HBLANK,
   input  logic                           VBLANK,
   output logic [7:0]                     RGB_out_R,
   output logic [7:0]                     RGB_out_G,
   output logic [7:0]                     RGB_out_B,
   output logic                           HS_out,
   output logic                           VS_out,
   output logic                           HBLANK_out,
   output logic                           VBLANK_out
);

   localparam int          W      = 4 * DIGITS;
   localparam int          GW     = 8 * SCALE;
   localparam logic [10:0] X_LO   = 11'(X_ORIGIN);
   localparam logic [10:0] X_HI   = 11'(X_ORIGIN + DIGITS * GW);
   localparam logic [10:0] Y_LO   = 11'(Y_ORIGIN);
   localparam logic [10:0] Y_HI   = 11'(Y_ORIGIN + NUM_VALUES * GW);
   localparam logic [9:0]  GW_V   = 10'(GW);
   localparam logic [9:0]  SCL_V  = 10'(SCALE);

   // Glyph rows packed MSB-first: bits [63:56] are row 0, bit 7 of a row
   // is the leftmost column. Column 7 and row 7 stay blank for spacing.
   function automatic logic [63:0] font_glyph(input logic [3:0] nib);
      case (nib)
         4'h0:    font_glyph = 64'h708898A8C8887000;
         4'h1:    font_glyph = 64'h2060202020207000;
         4'h2:    font_glyph = 64'h708808102040F800;
         4'h3:    font_glyph = 64'hF810201008887000;
         4'h4:    font_glyph = 64'h10305090F8101000;
         4'h5:    font_glyph = 64'hF880F00808887000;
         4'h6:    font_glyph = 64'h304080F088887000;
         4'h7:    font_glyph = 64'hF808102040404000;
         4'h8:    font_glyph = 64'h7088887088887000;
         4'h9:    font_glyph = 64'h7088887808106000;
         4'hA:    font_glyph = 64'h708888F888888800;
         4'hB:    font_glyph = 64'hF08888F08888F000;
         4'hC:    font_glyph = 64'h7088808080887000;
         4'hD:    font_glyph = 64'hE09088888890E000;
         4'hE:    font_glyph = 64'hF88080F08080F800;
         default: font_glyph = 64'hF88080F080808000;
      endcase
   endfunction

   // Position tracking and frame snapshot
   logic [9:0]                     hpos;
   logic [9:0]                     vpos;
   logic                           hblank_q;
   logic                           vblank_q;
   logic [NUM_VALUES*W-1:0]        snap;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hpos     <= '0;
         vpos     <= '0;
         hblank_q <= 1'b0;
         vblank_q <= 1'b0;
         snap     <= '0;
      end else if (pixel_ce) begin
         hblank_q <= HBLANK;
         vblank_q <= VBLANK;
         if (HBLANK)
            hpos <= '0;
         else if (hpos != '1)
            hpos <= hpos + 10'd1;
         if (VBLANK)
            vpos <= '0;
         else if (HBLANK && !hblank_q && vpos != '1)
            vpos <= vpos + 10'd1;
         if (VBLANK && !vblank_q)
            snap <= values;
      end
   end

   // Cell decode for the current pixel
   logic            in_box;
   logic [9:0]      dx;
   logic [9:0]      dy;
   logic [9:0]      line_idx;
   logic [9:0]      digit_idx;
   logic [9:0]      row_off;
   logic [9:0]      col_off;
   logic [2:0]      grow;
   logic [2:0]      gcol;
   logic [W-1:0]    word;
   logic [3:0]      nib;

   always_comb begin
      in_box    = ({1'b0, hpos} >= X_LO) && ({1'b0, hpos} < X_HI) &&
                  ({1'b0, vpos} >= Y_LO) && ({1'b0, vpos} < Y_HI);
      dx        = hpos - X_LO[9:0];
      dy        = vpos - Y_LO[9:0];
      line_idx  = dy / GW_V;
      digit_idx = dx / GW_V;
      row_off   = dy % GW_V;
      col_off   = dx % GW_V;
      grow      = 3'(row_off / SCL_V);
      gcol      = 3'(col_off / SCL_V);
      word      = '0;
      for (int unsigned i = 0; i < NUM_VALUES; i++)
         if (line_idx == 10'(i))
            word = snap[i*W +: W];
      // digit 0 is the most significant nibble of the word
      nib = '0;
      for (int unsigned d = 0; d < DIGITS; d++)
         if (digit_idx == 10'(d))
            nib = word[W-1-4*d -: 4];
   end

   // Stage 1 registers
   logic            s1_box;
   logic            s1_en;
   logic [3:0]      s1_nib;
   logic [2:0]      s1_row;
   logic [2:0]      s1_col;
   logic [23:0]     s1_rgb;
   logic            s1_hs;
   logic            s1_vs;
   logic            s1_hb;
   logic            s1_vb;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_box <= 1'b0;
         s1_en  <= 1'b0;
         s1_nib <= '0;
         s1_row <= '0;
         s1_col <= '0;
         s1_rgb <= '0;
         s1_hs  <= 1'b0;
         s1_vs  <= 1'b0;
         s1_hb  <= 1'b0;
         s1_vb  <= 1'b0;
      end else if (pixel_ce) begin
         s1_box <= in_box;
         s1_en  <= enable;
         s1_nib <= nib;
         s1_row <= grow;
         s1_col <= gcol;
         s1_rgb <= {RGB_in_R, RGB_in_G, RGB_in_B};
         s1_hs  <= HS;
         s1_vs  <= VS;
         s1_hb  <= HBLANK;
         s1_vb  <= VBLANK;
      end
   end

   // Stage 2 font lookup and mix
   logic [63:0]     glyph;
   logic [7:0]      row_bits;
   logic            fg_bit;
   logic [23:0]     mix_rgb;

   always_comb begin
      glyph    = font_glyph(s1_nib);
      // ~row == 7-row for a 3-bit index, so row 0 lands on bits [63:56]
      row_bits = glyph[{~s1_row, 3'b000} +: 8];
      fg_bit   = row_bits[~s1_col];
      if (s1_hb || s1_vb)
         mix_rgb = '0;
      else if (!s1_en || !s1_box)
         mix_rgb = s1_rgb;
      else if (fg_bit)
         mix_rgb = FG_RGB;
      else begin
         case (BG_MODE)
            0:       mix_rgb = s1_rgb;
            1:       mix_rgb = {1'b0, s1_rgb[23:17], 1'b0, s1_rgb[15:9], 1'b0, s1_rgb[7:1]};
            default: mix_rgb = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         RGB_out_R  <= '0;
         RGB_out_G  <= '0;
         RGB_out_B  <= '0;
         HS_out     <= 1'b0;
         VS_out     <= 1'b0;
         HBLANK_out <= 1'b0;
         VBLANK_out <= 1'b0;
      end else if (pixel_ce) begin
         RGB_out_R  <= mix_rgb[23:16];
         RGB_out_G  <= mix_rgb[15:8];
         RGB_out_B  <= mix_rgb[7:0];
         HS_out     <= s1_hs;
         VS_out     <= s1_vs;
         HBLANK_out <= s1_hb;
         VBLANK_out <= s1_vb;
      end
   end

endmodule

// File: tb/tb_osd_hex_overlay_multi.sv
// tb_osd_hex_overlay_multi
//   Drives a small synthetic video raster into three overlay instances
//   (SCALE/BG_MODE variants) and compares every output against a
//   pixel-coordinate-based reference model, plus fixed pixel expectations.
module tb_osd_hex_overlay_multi;

   localparam int H_ACT = 52, H_BL = 6, V_ACT = 42, V_BL = 3;
   localparam int XO = 16, YO = 8, NV = 2, DG = 2;

   localparam logic [63:0] FONT_TB [16] = '{
      64'h708898A8C8887000, 64'h2060202020207000, 64'h708808102040F800, 64'hF810201008887000,
      64'h10305090F8101000, 64'hF880F00808887000, 64'h304080F088887000, 64'hF808102040404000,
      64'h7088887088887000, 64'h7088887808106000, 64'h708888F888888800, 64'hF08888F08888F000,
      64'h7088808080887000, 64'hE09088888890E000, 64'hF88080F08080F800, 64'hF88080F080808000};

   int sc_of [3] = '{1, 1, 2};
   int bg_of [3] = '{2, 1, 0};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n = 1'b0, pixel_ce = 1'b0, enable = 1'b1;
   logic [15:0] values = '0;
   logic [7:0]  rin = '0, gin = '0, bin = '0;
   logic        hs = 1'b0, vs = 1'b0, hb = 1'b0, vb = 1'b0;

   logic [2:0][7:0] o_r, o_g, o_b;
   logic [2:0]      o_hs, o_vs, o_hb, o_vb;

   osd_hex_overlay_multi #(.NUM_VALUES(NV), .DIGITS(DG), .X_ORIGIN(XO), .Y_ORIGIN(YO),
      .SCALE(1), .BG_MODE(2), .FG_RGB(24'hFFFFFF)) dut_a (
      .clk(clk), .reset_n(reset_n), .pixel_ce(pixel_ce), .enable(enable), .values(values),
      .RGB_in_R(rin), .RGB_in_G(gin), .RGB_in_B(bin), .HS(hs), .VS(vs), .HBLANK(hb), .VBLANK(vb),
      .RGB_out_R(o_r[0]), .RGB_out_G(o_g[0]), .RGB_out_B(o_b[0]),
      .HS_out(o_hs[0]), .VS_out(o_vs[0]), .HBLANK_out(o_hb[0]), .VBLANK_out(o_vb[0]));

   osd_hex_overlay_multi #(.NUM_VALUES(NV), .DIGITS(DG), .X_ORIGIN(XO), .Y_ORIGIN(YO),
      .SCALE(1), .BG_MODE(1), .FG_RGB(24'hFFFFFF)) dut_b (
      .clk(clk), .reset_n(reset_n), .pixel_ce(pixel_ce), .enable(enable), .values(values),
      .RGB_in_R(rin), .RGB_in_G(gin), .RGB_in_B(bin), .HS(hs), .VS(vs), .HBLANK(hb), .VBLANK(vb),
      .RGB_out_R(o_r[1]), .RGB_out_G(o_g[1]), .RGB_out_B(o_b[1]),
      .HS_out(o_hs[1]), .VS_out(o_vs[1]), .HBLANK_out(o_hb[1]), .VBLANK_out(o_vb[1]));

   osd_hex_overlay_multi #(.NUM_VALUES(NV), .DIGITS(DG), .X_ORIGIN(XO), .Y_ORIGIN(YO),
      .SCALE(2), .BG_MODE(0), .FG_RGB(24'hFFFFFF)) dut_c (
      .clk(clk), .reset_n(reset_n), .pixel_ce(pixel_ce), .enable(enable), .values(values),
      .RGB_in_R(rin), .RGB_in_G(gin), .RGB_in_B(bin), .HS(hs), .VS(vs), .HBLANK(hb), .VBLANK(vb),
      .RGB_out_R(o_r[2]), .RGB_out_G(o_g[2]), .RGB_out_B(o_b[2]),
      .HS_out(o_hs[2]), .VS_out(o_vs[2]), .HBLANK_out(o_hb[2]), .VBLANK_out(o_vb[2]));

   int total = 0, bad = 0;

   task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s inst=%0d t=%0t got=%h expected=%h", nm, inst, $time, act, exp);
      end
   endtask

   // Reference: what a pixel at active coordinate (x,y) must look like.
   function automatic logic [23:0] model_pix(input int scale, input int bg, input int x, input int y,
                                             input logic [15:0] sn, input logic [23:0] rgb,
                                             input logic en, input logic blank);
      int gw, dx, dy, ln, dig, row, col, nib;
      gw = 8 * scale;
      if (blank) return 24'h0;
      if (!en) return rgb;
      if (x < XO || x >= XO + DG*gw || y < YO || y >= YO + NV*gw) return rgb;
      dx = x - XO; dy = y - YO;
      ln = dy / gw; dig = dx / gw;
      row = (dy % gw) / scale; col = (dx % gw) / scale;
      nib = int'((sn >> (ln*4*DG + (DG-1-dig)*4)) & 16'hF);
      if (FONT_TB[nib][63 - 8*row - col]) return 24'hFFFFFF;
      if (bg == 0) return rgb;
      if (bg == 1) return {1'b0, rgb[23:17], 1'b0, rgb[15:9], 1'b0, rgb[7:1]};
      return 24'h0;
   endfunction

   // Model state: pending (one tick in flight) and expected (on the outputs)
   logic [2:0][23:0] p_rgb = '0, e_rgb = '0;
   logic [3:0]       p_sync = '0, e_sync = '0;
   logic             p_valid = 1'b1, e_valid = 1'b1, p_act = 1'b0, e_act = 1'b0;
   int               p_x = 0, p_y = 0, p_f = 0, e_x = 0, e_y = 0, e_f = 0;
   logic [15:0]      m_snap = '0;
   logic             m_prev_vb = 1'b0;
   logic             frame_valid = 1'b0;
   int               cur_x = 0, cur_y = 0, cur_f = 0;
   int               tick_no = 0;
   logic             run = 1'b0;

   task automatic run_tick(input int duty);
      for (int k = 0; k < duty; k++) begin
         pixel_ce = (k == duty - 1);
         @(posedge clk);
         #1;
         if (!reset_n) begin
            p_rgb = '0; e_rgb = '0; p_sync = '0; e_sync = '0;
            p_valid = 1'b1; e_valid = 1'b1; p_act = 1'b0; e_act = 1'b0;
            m_snap = '0; m_prev_vb = 1'b0; frame_valid = 1'b0;
         end else if (pixel_ce) begin
            e_rgb = p_rgb; e_sync = p_sync; e_valid = p_valid;
            e_act = p_act; e_x = p_x; e_y = p_y; e_f = p_f;
            for (int i = 0; i < 3; i++)
               p_rgb[i] = model_pix(sc_of[i], bg_of[i], cur_x, cur_y, m_snap,
                                    {rin, gin, bin}, enable, hb | vb);
            p_sync = {hs, vs, hb, vb};
            p_valid = frame_valid;
            p_act = !(hb || vb);
            p_x = cur_x; p_y = cur_y; p_f = cur_f;
            if (vb && !m_prev_vb) m_snap = values;
            m_prev_vb = vb;
            tick_no++;
         end
         run = 1'b1;
      end
   endtask

   // Fixed pixel expectations (red channel; inputs are grey C8 in frames 1-2)
   localparam int NL = 15;
   int         lit_f [NL] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2};
   int         lit_i [NL] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 0, 0, 2, 0, 0};
   int         lit_x [NL] = '{17, 16, 31, 16, 0, 17, 18, 16, 47, 17, 19, 16, 16, 17, 19};
   int         lit_y [NL] = '{8, 8, 23, 8, 0, 8, 8, 8, 39, 14, 18, 21, 21, 14, 18};
   logic [7:0] lit_v [NL] = '{8'hFF, 8'h00, 8'h00, 8'h64, 8'hC8, 8'hFF, 8'hFF, 8'hC8, 8'hC8,
                              8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
   int         last_tick = -1;

   always @(negedge clk) begin
      if (run) begin
         for (int i = 0; i < 3; i++) begin
            chk("sync", i, {28'd0, o_hs[i], o_vs[i], o_hb[i], o_vb[i]}, {28'd0, e_sync});
            if (e_valid)
               chk("rgb", i, {8'd0, o_r[i], o_g[i], o_b[i]}, {8'd0, e_rgb[i]});
         end
         if (tick_no != last_tick) begin
            last_tick = tick_no;
            if (e_valid && e_act)
               for (int l = 0; l < NL; l++)
                  if (e_f == lit_f[l] && e_x == lit_x[l] && e_y == lit_y[l])
                     chk($sformatf("pixel(%0d,%0d)f%0d", lit_x[l], lit_y[l], lit_f[l]),
                         lit_i[l], {24'd0, o_r[lit_i[l]]}, {24'd0, lit_v[l]});
         end
      end
   end

   initial begin
      int duty;
      logic [7:0] g;
      values = 16'h3CA5;
      for (int f = 0; f < 8; f++) begin
         duty = (f < 4) ? 1 : (f < 6) ? 2 : 4;
         cur_f = f;
         if (f >= 1) frame_valid = 1'b1;
         if (f < 3) enable = 1'b1;
         else if (f == 3) enable = 1'b0;
         else if (f == 4) enable = 1'b1;
         for (int ln = 0; ln < V_ACT + V_BL; ln++) begin
            for (int p = 0; p < H_ACT + H_BL; p++) begin
               vb = (ln >= V_ACT);
               vs = (ln == V_ACT + 1);
               hb = (p >= H_ACT);
               hs = (p >= H_ACT + 1) && (p < H_ACT + 4);
               cur_x = p; cur_y = ln;
               reset_n = !((f == 0 && ln == 0 && p < 5) || (f == 4 && ln == 10 && p >= 20 && p < 23));
               if (f == 1 || f == 2) begin
                  rin = 8'hC8; gin = 8'hC8; bin = 8'hC8;
               end else begin
                  g = 8'($urandom); rin = g;
                  g = 8'($urandom); gin = g;
                  g = 8'($urandom); bin = g;
               end
               if (f >= 4 && $urandom_range(0, 49) == 0) enable = ~enable;
               if (f == 1 && ln == 20 && p == 0) values = 16'h0000;
               else if (f == 2 && ln == 30 && p == 0) values = 16'($urandom);
               else if (f >= 3 && $urandom_range(0, 199) == 0) values = 16'($urandom);
               run_tick(duty);
            end
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
